sap_register_bank: RTL and testbench
====================================

# sap_register_bank

Parametrised register bank for the SAP-style datapath: NUM_REGS registers of WIDTH bits sharing one command port and one read port toward the bus. Each command selects one register and can load it, clear it, increment or decrement it, shift it, or rotate it left by N positions over multiple cycles. The bank generalises the fixed single 8-bit bus register. It supplies carry/zero flags and a busy handshake to the control sequencer.

## Interface
- WIDTH, 8, register width in bits (≥2).
- NUM_REGS, 4, number of registers (≥2); ADDR_W = max(1, clog2(NUM_REGS)), derived, not overridable.
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- op_valid  in  1  command strobe, sampled on the rising edge.
- op  in  3  command code (see Operation).
- sel  in  ADDR_W  target register of the command.
- bus_in  in  WIDTH  data for LOAD; bits [clog2(WIDTH)-1:0] give the rotate amount for ROTL_N.
- n_enable  in  1  active-low read enable.
- rd_sel  in  ADDR_W  register driven on bus_out.
- bus_out  out  WIDTH  reg[rd_sel] when n_enable=0, else 0.
- bus_oe  out  1  ~n_enable.
- value  out  NUM_REGS*WIDTH  all registers flattened, reg i at [i*WIDTH +: WIDTH].
- carry  out  1  carry/borrow/shifted-out bit of the last completed op.
- zero  out  1  1 when the result of the last completed op is 0.
- busy  out  1  multi-cycle rotate in progress; commands are ignored while high.

## Operation
- Op codes:
  - 000 NOP.
  - 001 LOAD: r=bus_in; carry unchanged.
  - 010 CLEAR: r=0, carry=0.
  - 011 INC: {carry,r}=r+1.
  - 100 DEC: r=r-1, carry=1 iff old r==0 (borrow).
  - 101 SHL1: carry=r[MSB], r=r<<1.
  - 110 SHR1: carry=r[0], logical shift right.
  - 111 ROTL_N.
- Arithmetic is modulo 2^WIDTH; zero is computed on the written result.
- NOP leaves all state and flags unchanged.
- States: IDLE, ROTATE. In ROTATE, an internal counter cnt holds the remaining steps.
- IDLE, op_valid=1, op=ROTL_N, k=bus_in amount:
  - k=0: completes in one cycle like a single-cycle op; r unchanged, carry=0, zero updated.
  - k>0: latch sel and k, go to ROTATE, busy=1.
- ROTATE: each edge rotates the latched register left by 1 and sets carry to the bit moved into the LSB. zero updates only on the final step. When cnt reaches 0, return to IDLE and set busy=0.
- op_valid while busy: the command is dropped silently, with no queueing.
- sel ≥ NUM_REGS: the command is ignored and flags are unchanged.
- rd_sel ≥ NUM_REGS: bus_out=0.
- Read path is combinational from the current registers. It shows intermediate rotate values and has no write bypass.

## Timing
- Reset values: all registers 0, carry 0, zero 0, busy 0, state IDLE. bus_out/bus_oe follow the inputs immediately.
- Single-cycle ops: the result and flags are visible after the edge that samples op_valid (latency 1).
- ROTL_N with k>0:
  - Edge E0 accepts the command and raises busy; there is no rotation yet.
  - Edges E1..Ek each rotate once.
  - busy falls at Ek. busy is high for exactly k cycles.
  - A new command is accepted at the edge where busy is first sampled low, which is E(k+1) at the earliest.
- rst asserted mid-rotate: the rotate aborts immediately (asynchronous), all state returns to reset values, and there is no partial writeback afterwards.
- bus_out and bus_oe have zero-cycle combinational latency from n_enable and rd_sel.

## Structure
- Shared package sap_pkg holds:
  - op code localparams/enum: OP_NOP .. OP_ROTL_N.
  - state enum: IDLE, ROTATE.
- The sub-module sap_reg_alu is a combinational next-value unit. Input: op, r. Output: next r, carry, zero. It is shared by single-cycle ops and each rotate step (fed OP_ROTL1 internally).
- The top level holds the register array, FSM, counter and read mux.

## Test plan
All scenarios use WIDTH=8, NUM_REGS=4.
1. Pulse rst for 2 cycles -> value=0, carry=0, zero=0, busy=0. With n_enable=0 and rd_sel=3 -> bus_out=0x00, bus_oe=1.
2. LOAD sel=2 bus_in=0xFF, then INC sel=2 -> reg2=0x00, carry=1, zero=1. Then DEC sel=2 -> reg2=0xFF, carry=1, zero=0.
3. LOAD sel=0 0x81, then SHR1 -> 0x40, carry=1. Then SHL1 -> 0x80, carry=0. Then CLEAR -> 0x00, carry=0, zero=1.
4. LOAD sel=1 0x81, then ROTL_N sel=1 bus_in=3:
   - busy high for 3 cycles.
   - reg1 steps through 0x03 → 0x06 → 0x0C.
   - Final state carry=0, zero=0.
   - An INC sel=0 issued while busy is ignored: reg0 is unchanged.
   - With n_enable=0 and rd_sel=1, bus_out=0x03 after E1.
5. ROTL_N sel=3 bus_in=0 -> busy never rises, reg3 unchanged, carry=0. A command on the next cycle is accepted.
6. Start ROTL_N k=5 on reg1=0x81 and assert rst after E2 -> busy=0 and all registers 0 within the same cycle. After release, a LOAD is accepted normally.

Source files
------------

// File: rtl/sap_pkg.sv
// Shared definitions for the SAP register bank: command codes and the
// rotate sequencer state.
package sap_pkg;

  // Commands are 3 bits on the port; the extra code OP_ROTL1 lets the ALU
  // perform one rotate step on behalf of the multi-cycle ROTL_N sequencer.
  typedef enum logic [3:0] {
    OP_NOP    = 4'd0,
    OP_LOAD   = 4'd1,
    OP_CLEAR  = 4'd2,
    OP_INC    = 4'd3,
    OP_DEC    = 4'd4,
    OP_SHL1   = 4'd5,
    OP_SHR1   = 4'd6,
    OP_ROTL_N = 4'd7,
    OP_ROTL1  = 4'd8
  } op_e;

  typedef enum logic {
    IDLE   = 1'b0,
    ROTATE = 1'b1
  } state_e;

  localparam int OP_W = 3;

endpackage

// File: rtl/sap_reg_alu.sv
// Combinational next-value unit for one register: computes the written value,
// carry and zero flag for a single command or a single rotate step.
module sap_reg_alu
  import sap_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  op_e              op,
  input  logic [WIDTH-1:0] r,
  input  logic [WIDTH-1:0] data,
  input  logic             carry_in,
  output logic [WIDTH-1:0] r_next,
  output logic             carry_next,
  output logic             zero_next
);

  always_comb begin
    r_next     = r;
    carry_next = carry_in;
    case (op)
      OP_LOAD:  r_next = data;
      OP_CLEAR: begin
        r_next     = '0;
        carry_next = 1'b0;
      end
      OP_INC:   {carry_next, r_next} = {1'b0, r} + {{WIDTH{1'b0}}, 1'b1};
      OP_DEC: begin
        r_next     = r - {{(WIDTH-1){1'b0}}, 1'b1};
        carry_next = (r == '0);
      end
      OP_SHL1: begin
        r_next     = {r[WIDTH-2:0], 1'b0};
        carry_next = r[WIDTH-1];
      end
      OP_SHR1: begin
        r_next     = {1'b0, r[WIDTH-1:1]};
        carry_next = r[0];
      end
      // A zero-length rotate leaves the value alone but still reports flags.
      OP_ROTL_N: carry_next = 1'b0;
      OP_ROTL1: begin
        r_next     = {r[WIDTH-2:0], r[WIDTH-1]};
        carry_next = r[WIDTH-1];
      end
      default: ;
    endcase
    zero_next = (r_next == '0);
  end

endmodule

// File: rtl/sap_register_bank.sv
// Bank of NUM_REGS registers behind one command port, with a multi-cycle
// rotate sequencer and a combinational read mux toward the bus.
module sap_register_bank
  import sap_pkg::*;
#(
  parameter  int WIDTH    = 8,
  parameter  int NUM_REGS = 4,
  localparam int ADDR_W   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      op_valid,
  input  logic [OP_W-1:0]           op,
  input  logic [ADDR_W-1:0]         sel,
  input  logic [WIDTH-1:0]          bus_in,
  input  logic                      n_enable,
  input  logic [ADDR_W-1:0]         rd_sel,
  output logic [WIDTH-1:0]          bus_out,
  output logic                      bus_oe,
  output logic [NUM_REGS*WIDTH-1:0] value,
  output logic                      carry,
  output logic                      zero,
  output logic                      busy
);

  localparam int AMT_W = $clog2(WIDTH);
  localparam logic [ADDR_W:0] NUM_REGS_L = (ADDR_W+1)'(NUM_REGS);

  state_e             state_q, state_d;
  logic [AMT_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]  lsel_q, lsel_d;
  logic [WIDTH-1:0]   regs_q [NUM_REGS];
  logic [WIDTH-1:0]   regs_d [NUM_REGS];
  logic               carry_q, carry_d;
  logic               zero_q, zero_d;

  op_e                cmd_op;
  op_e                alu_op;
  logic [ADDR_W-1:0]  wr_idx;
  logic [AMT_W-1:0]   amt;
  logic               sel_ok;
  logic               rd_ok;
  logic [WIDTH-1:0]   alu_r_next;
  logic               alu_carry;
  logic               alu_zero;

  assign cmd_op = op_e'({1'b0, op});
  assign amt    = bus_in[AMT_W-1:0];
  assign sel_ok = ({1'b0, sel} < NUM_REGS_L);
  assign rd_ok  = ({1'b0, rd_sel} < NUM_REGS_L);
  assign wr_idx = (state_q == ROTATE) ? lsel_q : sel;
  assign alu_op = (state_q == ROTATE) ? OP_ROTL1 : cmd_op;

  sap_reg_alu #(.WIDTH(WIDTH)) u_alu (
    .op         (alu_op),
    .r          (regs_q[wr_idx]),
    .data       (bus_in),
    .carry_in   (carry_q),
    .r_next     (alu_r_next),
    .carry_next (alu_carry),
    .zero_next  (alu_zero)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lsel_d  = lsel_q;
    regs_d  = regs_q;
    carry_d = carry_q;
    zero_d  = zero_q;
    case (state_q)
      IDLE: begin
        if (op_valid && sel_ok && cmd_op != OP_NOP) begin
          if (cmd_op == OP_ROTL_N && amt != '0) begin
            state_d = ROTATE;
            cnt_d   = amt;
            lsel_d  = sel;
          end else begin
            regs_d[sel] = alu_r_next;
            carry_d     = alu_carry;
            zero_d      = alu_zero;
          end
        end
      end
      ROTATE: begin
        // Commands arriving here are dropped; only the latched target moves.
        regs_d[lsel_q] = alu_r_next;
        carry_d        = alu_carry;
        cnt_d          = cnt_q - AMT_W'(1);
        if (cnt_q == AMT_W'(1)) begin
          zero_d  = alu_zero;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      lsel_q  <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lsel_q  <= lsel_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
    end
  end

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
    always_ff @(posedge clk or posedge rst) begin
      if (rst) regs_q[gi] <= '0;
      else     regs_q[gi] <= regs_d[gi];
    end
    assign value[gi*WIDTH +: WIDTH] = regs_q[gi];
  end

  assign bus_out = (!n_enable && rd_ok) ? regs_q[rd_sel] : '0;
  assign bus_oe  = ~n_enable;
  assign carry   = carry_q;
  assign zero    = zero_q;
  assign busy    = (state_q == ROTATE);

endmodule

// File: tb/tb_sap_register_bank.sv
// Scenario bench for sap_register_bank (WIDTH=8, NUM_REGS=4): expected bank
// snapshots are queued as each command is driven and compared after the edge.
module tb_sap_register_bank;

  localparam logic [2:0] C_NOP = 3'd0, C_LOAD = 3'd1, C_CLR = 3'd2, C_INC = 3'd3,
                         C_DEC = 3'd4, C_SHL = 3'd5, C_SHR = 3'd6, C_ROT = 3'd7;

  logic        clk, rst, op_valid, n_enable, bus_oe, carry, zero, busy;
  logic [2:0]  op;
  logic [1:0]  sel, rd_sel;
  logic [7:0]  bus_in, bus_out;
  logic [31:0] value;

  int n_checks = 0;
  int n_fail   = 0;

  // Snapshot layout: {value[31:0], carry, zero, busy, bus_out[7:0]}
  typedef struct {
    logic        valid;
    logic [2:0]  op;
    logic [1:0]  sel;
    logic [7:0]  data;
    logic [42:0] exp;
  } cmd_t;

  logic [42:0] exp_q[$];

  sap_register_bank #(.WIDTH(8), .NUM_REGS(4)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op(op), .sel(sel),
    .bus_in(bus_in), .n_enable(n_enable), .rd_sel(rd_sel), .bus_out(bus_out),
    .bus_oe(bus_oe), .value(value), .carry(carry), .zero(zero), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [42:0] mk(input logic [31:0] v, input logic c, input logic z,
                                     input logic b, input logic [7:0] bo);
    return {v, c, z, b, bo};
  endfunction

  function automatic logic [42:0] obs();
    return {value, carry, zero, busy, bus_out};
  endfunction

  task automatic step(input cmd_t c);
    op_valid = c.valid;
    op       = c.op;
    sel      = c.sel;
    bus_in   = c.data;
    exp_q.push_back(c.exp);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; op_valid = 1'b0; op = C_NOP; sel = 2'd0; bus_in = 8'h00;
    n_enable = 1'b0; rd_sel = 2'd3;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (obs() !== mk(32'h0, 1'b0, 1'b0, 1'b0, 8'h00)) begin
      n_fail++; $display("FAIL reset_state: got %h, expected %h", obs(), mk(32'h0, 1'b0, 1'b0, 1'b0, 8'h00));
    end else $display("reset: value=%h carry=%b zero=%b busy=%b bus_out=%h", value, carry, zero, busy, bus_out);
    n_checks++;
    if (bus_oe !== 1'b1) begin
      n_fail++; $display("FAIL reset_bus_oe: got %b, expected 1", bus_oe);
    end else $display("reset: bus_oe=%b with n_enable=0", bus_oe);
    n_enable = 1'b1;
    #1;
    n_checks++;
    if ({bus_oe, bus_out} !== 9'h000) begin
      n_fail++; $display("FAIL read_disabled: got oe=%b out=%h, expected oe=0 out=00", bus_oe, bus_out);
    end else $display("read disabled: bus_oe=%b bus_out=%h", bus_oe, bus_out);
    rst = 1'b0;
  endtask

  task automatic test_arith();
    cmd_t cmds [4];
    logic [42:0] e;
    cmds = '{
      '{1'b1, C_LOAD, 2'd2, 8'hFF, mk(32'h00FF0000, 1'b0, 1'b0, 1'b0, 8'hFF)},
      '{1'b1, C_INC,  2'd2, 8'h00, mk(32'h00000000, 1'b1, 1'b1, 1'b0, 8'h00)},
      '{1'b1, C_DEC,  2'd2, 8'h00, mk(32'h00FF0000, 1'b1, 1'b0, 1'b0, 8'hFF)},
      '{1'b1, C_NOP,  2'd2, 8'h12, mk(32'h00FF0000, 1'b1, 1'b0, 1'b0, 8'hFF)}
    };
    n_enable = 1'b0; rd_sel = 2'd2;
    foreach (cmds[i]) begin
      step(cmds[i]);
      e = exp_q.pop_front();
      n_checks++;
      if (obs() !== e) begin
        n_fail++; $display("FAIL arith[%0d]: got %h, expected %h", i, obs(), e);
      end else $display("arith[%0d] op=%0d sel=%0d: value=%h c=%b z=%b busy=%b bus_out=%h",
                        i, cmds[i].op, cmds[i].sel, value, carry, zero, busy, bus_out);
    end
  endtask

  task automatic test_shift();
    cmd_t cmds [4];
    logic [42:0] e;
    cmds = '{
      '{1'b1, C_LOAD, 2'd0, 8'h81, mk(32'h00FF0081, 1'b1, 1'b0, 1'b0, 8'h81)},
      '{1'b1, C_SHR,  2'd0, 8'h00, mk(32'h00FF0040, 1'b1, 1'b0, 1'b0, 8'h40)},
      '{1'b1, C_SHL,  2'd0, 8'h00, mk(32'h00FF0080, 1'b0, 1'b0, 1'b0, 8'h80)},
      '{1'b1, C_CLR,  2'd0, 8'h00, mk(32'h00FF0000, 1'b0, 1'b1, 1'b0, 8'h00)}
    };
    n_enable = 1'b0; rd_sel = 2'd0;
    foreach (cmds[i]) begin
      step(cmds[i]);
      e = exp_q.pop_front();
      n_checks++;
      if (obs() !== e) begin
        n_fail++; $display("FAIL shift[%0d]: got %h, expected %h", i, obs(), e);
      end else $display("shift[%0d] op=%0d sel=%0d: value=%h c=%b z=%b busy=%b bus_out=%h",
                        i, cmds[i].op, cmds[i].sel, value, carry, zero, busy, bus_out);
    end
  endtask

  task automatic test_rotate();
    cmd_t cmds [5];
    logic [42:0] e;
    // INCs on reg0 during busy must be dropped; busy is sampled high exactly 3 times.
    cmds = '{
      '{1'b1, C_LOAD, 2'd1, 8'h81, mk(32'h00FF8100, 1'b0, 1'b0, 1'b0, 8'h81)},
      '{1'b1, C_ROT,  2'd1, 8'h03, mk(32'h00FF8100, 1'b0, 1'b0, 1'b1, 8'h81)},
      '{1'b1, C_INC,  2'd0, 8'h00, mk(32'h00FF0300, 1'b1, 1'b0, 1'b1, 8'h03)},
      '{1'b1, C_INC,  2'd0, 8'h00, mk(32'h00FF0600, 1'b0, 1'b0, 1'b1, 8'h06)},
      '{1'b0, C_NOP,  2'd0, 8'h00, mk(32'h00FF0C00, 1'b0, 1'b0, 1'b0, 8'h0C)}
    };
    n_enable = 1'b0; rd_sel = 2'd1;
    foreach (cmds[i]) begin
      step(cmds[i]);
      e = exp_q.pop_front();
      n_checks++;
      if (obs() !== e) begin
        n_fail++; $display("FAIL rotate[%0d]: got %h, expected %h", i, obs(), e);
      end else $display("rotate[%0d] op=%0d sel=%0d: value=%h c=%b z=%b busy=%b bus_out=%h",
                        i, cmds[i].op, cmds[i].sel, value, carry, zero, busy, bus_out);
    end
  endtask

  task automatic test_rotate_zero();
    cmd_t cmds [4];
    logic [42:0] e;
    cmds = '{
      '{1'b1, C_LOAD, 2'd3, 8'h5A, mk(32'h5AFF0C00, 1'b0, 1'b0, 1'b0, 8'h5A)},
      '{1'b1, C_INC,  2'd2, 8'h00, mk(32'h5A000C00, 1'b1, 1'b1, 1'b0, 8'h5A)},
      '{1'b1, C_ROT,  2'd3, 8'h00, mk(32'h5A000C00, 1'b0, 1'b0, 1'b0, 8'h5A)},
      '{1'b1, C_DEC,  2'd3, 8'h00, mk(32'h59000C00, 1'b0, 1'b0, 1'b0, 8'h59)}
    };
    n_enable = 1'b0; rd_sel = 2'd3;
    foreach (cmds[i]) begin
      step(cmds[i]);
      e = exp_q.pop_front();
      n_checks++;
      if (obs() !== e) begin
        n_fail++; $display("FAIL rot_zero[%0d]: got %h, expected %h", i, obs(), e);
      end else $display("rot_zero[%0d] op=%0d sel=%0d: value=%h c=%b z=%b busy=%b bus_out=%h",
                        i, cmds[i].op, cmds[i].sel, value, carry, zero, busy, bus_out);
    end
  endtask

  task automatic test_back_to_back();
    cmd_t cmds [5];
    logic [42:0] e;
    // ROTL_N k=1: the INC at E1 is dropped, the LOAD at E2 is the first accepted.
    cmds = '{
      '{1'b1, C_LOAD, 2'd0, 8'h33, mk(32'h59000C33, 1'b0, 1'b0, 1'b0, 8'h33)},
      '{1'b1, C_ROT,  2'd0, 8'h01, mk(32'h59000C33, 1'b0, 1'b0, 1'b1, 8'h33)},
      '{1'b1, C_INC,  2'd3, 8'h00, mk(32'h59000C66, 1'b0, 1'b0, 1'b0, 8'h66)},
      '{1'b1, C_LOAD, 2'd0, 8'h01, mk(32'h59000C01, 1'b0, 1'b0, 1'b0, 8'h01)},
      '{1'b1, C_SHL,  2'd0, 8'h00, mk(32'h59000C02, 1'b0, 1'b0, 1'b0, 8'h02)}
    };
    n_enable = 1'b0; rd_sel = 2'd0;
    foreach (cmds[i]) begin
      step(cmds[i]);
      e = exp_q.pop_front();
      n_checks++;
      if (obs() !== e) begin
        n_fail++; $display("FAIL b2b[%0d]: got %h, expected %h", i, obs(), e);
      end else $display("b2b[%0d] op=%0d sel=%0d: value=%h c=%b z=%b busy=%b bus_out=%h",
                        i, cmds[i].op, cmds[i].sel, value, carry, zero, busy, bus_out);
    end
  endtask

  task automatic test_reset_mid_rotate();
    cmd_t cmds [4];
    cmd_t after [2];
    logic [42:0] e;
    cmds = '{
      '{1'b1, C_LOAD, 2'd1, 8'h81, mk(32'h59008102, 1'b0, 1'b0, 1'b0, 8'h81)},
      '{1'b1, C_ROT,  2'd1, 8'h05, mk(32'h59008102, 1'b0, 1'b0, 1'b1, 8'h81)},
      '{1'b0, C_NOP,  2'd0, 8'h00, mk(32'h59000302, 1'b1, 1'b0, 1'b1, 8'h03)},
      '{1'b0, C_NOP,  2'd0, 8'h00, mk(32'h59000602, 1'b0, 1'b0, 1'b1, 8'h06)}
    };
    after = '{
      '{1'b0, C_NOP,  2'd0, 8'h00, mk(32'h00000000, 1'b0, 1'b0, 1'b0, 8'h00)},
      '{1'b1, C_LOAD, 2'd0, 8'h33, mk(32'h00000033, 1'b0, 1'b0, 1'b0, 8'h00)}
    };
    n_enable = 1'b0; rd_sel = 2'd1;
    foreach (cmds[i]) begin
      step(cmds[i]);
      e = exp_q.pop_front();
      n_checks++;
      if (obs() !== e) begin
        n_fail++; $display("FAIL rst_mid[%0d]: got %h, expected %h", i, obs(), e);
      end else $display("rst_mid[%0d] op=%0d sel=%0d: value=%h c=%b z=%b busy=%b bus_out=%h",
                        i, cmds[i].op, cmds[i].sel, value, carry, zero, busy, bus_out);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (obs() !== mk(32'h0, 1'b0, 1'b0, 1'b0, 8'h00)) begin
      n_fail++; $display("FAIL async_reset: got %h, expected %h", obs(), mk(32'h0, 1'b0, 1'b0, 1'b0, 8'h00));
    end else $display("async reset mid-rotate: value=%h busy=%b", value, busy);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    foreach (after[i]) begin
      step(after[i]);
      e = exp_q.pop_front();
      n_checks++;
      if (obs() !== e) begin
        n_fail++; $display("FAIL post_reset[%0d]: got %h, expected %h", i, obs(), e);
      end else $display("post_reset[%0d] op=%0d sel=%0d: value=%h c=%b z=%b busy=%b bus_out=%h",
                        i, after[i].op, after[i].sel, value, carry, zero, busy, bus_out);
    end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_shift();
    test_rotate();
    test_rotate_zero();
    test_back_to_back();
    test_reset_mid_rotate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
